// File: rtl/battleship_pkg.sv
// Shared Battleships definitions: game state encoding, counter widths and
// default game size, so the board logic and the display agree on them.
package battleship_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WON  = 2'd2,
        ST_LOST = 2'd3
    } game_state_e;

    localparam int TURNS_W       = 5;
    localparam int SHIPS_W       = 3;
    localparam int DEF_NUM_TURNS = 20;
    localparam int DEF_NUM_SHIPS = 5;

    // Decrement a turn count, holding at zero instead of wrapping.
    function automatic logic [TURNS_W-1:0] turns_dec_sat(input logic [TURNS_W-1:0] val);
        if (val == {TURNS_W{1'b0}}) begin
            turns_dec_sat = {TURNS_W{1'b0}};
        end else begin
            turns_dec_sat = val - {{(TURNS_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Decrement a ship count, holding at zero instead of wrapping.
    function automatic logic [SHIPS_W-1:0] ships_dec_sat(input logic [SHIPS_W-1:0] val);
        if (val == {SHIPS_W{1'b0}}) begin
            ships_dec_sat = {SHIPS_W{1'b0}};
        end else begin
            ships_dec_sat = val - {{(SHIPS_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Retriggerable pulse stretcher: a trig pulse makes out high for exactly
// CYCLES clocks starting on the following cycle; a new trig restarts the
// window. Reset has priority over trig.
module pulse_stretcher #(
    parameter int CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic trig,
    output logic out
);

    localparam int CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    logic [CNT_W-1:0] cnt_r;
    logic             out_r;

    // Count down the remaining window; the trig edge itself supplies the
    // first high cycle, cnt_r covers the remaining CYCLES-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
            out_r <= 1'b0;
        end else if (trig) begin
            cnt_r <= CNT_W'(CYCLES - 1);
            out_r <= 1'b1;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            out_r <= 1'b1;
        end else begin
            cnt_r <= cnt_r;
            out_r <= 1'b0;
        end
    end

    assign out = out_r;

endmodule

// File: rtl/game_status_tracker.sv
// Battleships game status: counts turns and ships down from shot-resolution
// events, decides win/loss and stretches hit/sink events into an LED flash.
module game_status_tracker
    import battleship_pkg::*;
#(
    parameter int NUM_TURNS    = DEF_NUM_TURNS,
    parameter int NUM_SHIPS    = DEF_NUM_SHIPS,
    parameter int FLASH_CYCLES = 25_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               shot_valid,
    input  logic               shot_hit,
    input  logic               shot_sunk,
    input  logic               shot_repeat,
    output logic [TURNS_W-1:0] turns_left,
    output logic [SHIPS_W-1:0] ships_remaining,
    output logic [1:0]         game_state,
    output logic               flash,
    output logic               flash_sunk
);

    game_state_e        state_r;
    logic [TURNS_W-1:0] turns_r;
    logic [SHIPS_W-1:0] ships_r;
    logic               sunk_tag_r;

    logic               counted_s;
    logic               flash_trig_s;
    logic               flash_clr_s;
    logic [TURNS_W-1:0] turns_next_s;
    logic [SHIPS_W-1:0] ships_next_s;
    logic               flash_s;

    // Qualify shots: only non-repeat shots in PLAY count, and start wins
    // over a shot arriving in the same cycle.
    always_comb begin
        counted_s    = 1'b0;
        flash_trig_s = 1'b0;
        turns_next_s = turns_dec_sat(turns_r);
        if (state_r == ST_PLAY && shot_valid && !shot_repeat && !start) begin
            counted_s    = 1'b1;
            flash_trig_s = shot_hit | shot_sunk;
        end else begin
            counted_s    = 1'b0;
            flash_trig_s = 1'b0;
        end
        // A sink flag alone is still a sink.
        if (shot_sunk) begin
            ships_next_s = ships_dec_sat(ships_r);
        end else begin
            ships_next_s = ships_r;
        end
    end

    // Game FSM with its counters; the win check uses the post-update ship
    // count first so a sink on the last turn is a win.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            turns_r <= {TURNS_W{1'b0}};
            ships_r <= {SHIPS_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_WON, ST_LOST: begin
                    if (start) begin
                        state_r <= ST_PLAY;
                        turns_r <= TURNS_W'(NUM_TURNS);
                        ships_r <= SHIPS_W'(NUM_SHIPS);
                    end else begin
                        state_r <= state_r;
                        turns_r <= turns_r;
                        ships_r <= ships_r;
                    end
                end
                ST_PLAY: begin
                    if (start) begin
                        state_r <= ST_PLAY;
                        turns_r <= TURNS_W'(NUM_TURNS);
                        ships_r <= SHIPS_W'(NUM_SHIPS);
                    end else if (counted_s) begin
                        turns_r <= turns_next_s;
                        ships_r <= ships_next_s;
                        if (ships_next_s == {SHIPS_W{1'b0}}) begin
                            state_r <= ST_WON;
                        end else if (turns_next_s == {TURNS_W{1'b0}}) begin
                            state_r <= ST_LOST;
                        end else begin
                            state_r <= ST_PLAY;
                        end
                    end else begin
                        state_r <= state_r;
                        turns_r <= turns_r;
                        ships_r <= ships_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    turns_r <= {TURNS_W{1'b0}};
                    ships_r <= {SHIPS_W{1'b0}};
                end
            endcase
        end
    end

    // Remember whether the most recent flash trigger was a sink; any start
    // drops the flash along with its tag.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            sunk_tag_r <= 1'b0;
        end else if (flash_trig_s) begin
            sunk_tag_r <= shot_sunk;
        end else begin
            sunk_tag_r <= sunk_tag_r;
        end
    end

    assign flash_clr_s = reset | start;

    pulse_stretcher #(
        .CYCLES (FLASH_CYCLES)
    ) u_flash (
        .clk   (clk),
        .reset (flash_clr_s),
        .trig  (flash_trig_s),
        .out   (flash_s)
    );

    assign turns_left      = turns_r;
    assign ships_remaining = ships_r;
    assign game_state      = state_r;
    assign flash           = flash_s;
    assign flash_sunk      = flash_s & sunk_tag_r;

endmodule
